branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
- ID-stage controller that sequences the branch comparator.
- Holds a branch in ID until its operands are forwarded-ready, then samples the comparator flags (equal, signed D1>=0, signed D1>0) and decodes them per branch opcode.
- Issues a registered taken/target decision to the next-PC mux and the IF/ID stall/flush logic.
- Keeps a wait-timeout error flag and saturating taken/stall statistics counters.

Parameters:
MAX_WAIT, 15, max cycles in WAIT before timeout (1..255)
COUNT_W, 16, width of statistics counters

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-low; reset==0 at a rising edge clears all state
br_valid  input  1  branch instruction present in ID
br_op  input  3  0 BEQ, 1 BNE, 2 BGEZ, 3 BGTZ, 4 BLEZ, 5 BLTZ, 6/7 illegal
rs_ready  input  1  rs value at comparator D1 is final
rt_ready  input  1  rt value at comparator D2 is final (ignored for ops 2..5)
cmp_equal  input  1  comparator D1==D2
cmp_g_or_e  input  1  comparator signed D1>=0
cmp_greater  input  1  comparator signed D1>0
id_pc  input  32  PC of the branch in ID
imm16  input  16  branch offset field
stall  output  1  hold PC and IF/ID (combinational)
br_done  output  1  one-cycle pulse: decision valid
br_taken  output  1  registered decision
br_target  output  32  registered branch target
err  output  1  sticky: timeout or illegal op
taken_cnt  output  COUNT_W  taken branches, saturating
stall_cnt  output  COUNT_W  cycles with stall=1, saturating

Behaviour:
- Reset values: state IDLE; br_done=0, br_taken=0, br_target=0, err=0, taken_cnt=0, stall_cnt=0, wait_cnt=0.
- Operand readiness: ops_ready = rs_ready & (rt_ready | br_op>=2).
- Taken decode:
  - BEQ: equal
  - BNE: !equal
  - BGEZ: g_or_e
  - BGTZ: greater
  - BLEZ: !greater
  - BLTZ: !g_or_e
  - ops 6/7: taken=0, and err is set at capture.
- Target: id_pc + 4 + (sign_extend(imm16) << 2), modulo 2^32 (wraps, no error).
- Capture: in the capture cycle, register br_taken, br_target and the err update; br_done=1 in the following cycle.
- State IDLE:
  - stall = br_valid.
  - br_valid & ops_ready: capture, go to RESOLVED.
  - br_valid & !ops_ready: go to WAIT with wait_cnt=1.
- State WAIT:
  - stall = br_valid.
  - br_valid=0 (flush): go to IDLE, no capture, no br_done.
  - ops_ready: capture, go to RESOLVED.
  - Otherwise, if wait_cnt==MAX_WAIT: set err, force br_taken=0, register br_target from current inputs, go to RESOLVED (timeout).
  - Otherwise wait_cnt += 1.
- State RESOLVED:
  - br_done=1, stall=0, so the branch leaves ID this cycle.
  - br_valid is ignored (same instruction).
  - Always returns to IDLE next cycle.
- Result hold: br_taken and br_target hold until the next capture; br_done is low outside RESOLVED.
- Latency: operands ready on arrival gives a 1-cycle stall and br_done one cycle after arrival; each not-ready cycle adds one.
- Counters: saturate at all-ones, never wrap.
  - stall_cnt += 1 every cycle stall=1.
  - taken_cnt += 1 on each RESOLVED cycle with br_taken=1.
- err: only reset clears it; further errors leave it 1.
- Reset mid-operation: reset==0 in any state returns to IDLE with reset values next edge and overrides every other event in that cycle; stall follows IDLE rules afterwards.
- Simultaneous events: in WAIT, ops_ready wins over timeout in the same cycle; flush (br_valid=0) wins over both.

Test Plan:
- BEQ ready on arrival: br_op=0, rs/rt_ready=1, cmp_equal=1, id_pc=0x00003000, imm16=0x0004.
  → stall=1 for 1 cycle, next cycle br_done=1, br_taken=1, br_target=0x00003014, taken_cnt=1.
- BLTZ negative offset with wrap: br_op=5, cmp_g_or_e=0, id_pc=0x00000000, imm16=0xFFFE.
  → br_taken=1, br_target=0xFFFFFFFC.
- Load-use wait: BNE with rt_ready=0 for 3 cycles, then 1, cmp_equal=1.
  → stall high 4 cycles, br_done on cycle 5, br_taken=0, stall_cnt=4, err=0.
- Timeout: MAX_WAIT=15, rs_ready held 0.
  → after 16 stall cycles br_done=1, br_taken=0, err=1 stays set through later good branches.
- Flush and illegal op, part 1: br_valid dropped in WAIT.
  → IDLE, no br_done, br_taken keeps its old value.
- Flush and illegal op, part 2: br_op=7 ready.
  → br_taken=0, err=1.
- Reset mid-WAIT: reset=0 for one edge.
  → all outputs zero, stall follows br_valid; counters saturate at 0xFFFF when preloaded near max via long stall run.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch resolution: waits for forwarded operands, decodes the
// comparator flags, and registers the taken/target decision.
module branch_resolve_ctrl #(
  parameter int MAX_WAIT = 15,
  parameter int COUNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               br_valid,
  input  logic [2:0]         br_op,
  input  logic               rs_ready,
  input  logic               rt_ready,
  input  logic               cmp_equal,
  input  logic               cmp_g_or_e,
  input  logic               cmp_greater,
  input  logic [31:0]        id_pc,
  input  logic [15:0]        imm16,
  output logic               stall,
  output logic               br_done,
  output logic               br_taken,
  output logic [31:0]        br_target,
  output logic               err,
  output logic [COUNT_W-1:0] taken_cnt,
  output logic [COUNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RES
  } state_t;

  localparam logic [7:0] LP_MAX = 8'(MAX_WAIT);

  state_t             r_state;
  logic [7:0]         r_wait_cnt;
  logic               r_taken;
  logic [31:0]        r_target;
  logic               r_err;
  logic [COUNT_W-1:0] r_tcnt;
  logic [COUNT_W-1:0] r_scnt;

  logic        w_ops_ready;
  logic        w_illegal;
  logic        w_taken;
  logic [31:0] w_target;
  logic        w_busy;
  logic        w_capture;
  logic        w_timeout;
  logic        w_stall;

  assign w_ops_ready = rs_ready & (rt_ready | (br_op >= 3'd2));
  assign w_illegal   = br_op[2] & br_op[1];
  assign w_target    = id_pc + 32'd4
                     + {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    w_taken = 1'b0;
    case (br_op)
      3'd0:    w_taken = cmp_equal;
      3'd1:    w_taken = ~cmp_equal;
      3'd2:    w_taken = cmp_g_or_e;
      3'd3:    w_taken = cmp_greater;
      3'd4:    w_taken = ~cmp_greater;
      3'd5:    w_taken = ~cmp_g_or_e;
      default: w_taken = 1'b0;
    endcase
  end

  assign w_busy    = (r_state == S_IDLE) | (r_state == S_WAIT);
  assign w_stall   = br_valid & w_busy;
  assign w_capture = w_stall & w_ops_ready;
  // ops_ready beats timeout; a dropped br_valid beats both
  assign w_timeout = br_valid & ~w_ops_ready
                   & (r_state == S_WAIT)
                   & (r_wait_cnt == LP_MAX);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 8'd0;
      r_taken    <= 1'b0;
      r_target   <= 32'd0;
      r_err      <= 1'b0;
      r_tcnt     <= '0;
      r_scnt     <= '0;
    end else begin
      if (w_stall && !(&r_scnt))
        r_scnt <= r_scnt + COUNT_W'(1);

      if (w_capture) begin
        r_taken  <= w_taken & ~w_illegal;
        r_target <= w_target;
        r_err    <= r_err | w_illegal;
      end else if (w_timeout) begin
        r_taken  <= 1'b0;
        r_target <= w_target;
        r_err    <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (br_valid && w_ops_ready) begin
            r_state <= S_RES;
          end else if (br_valid) begin
            r_state    <= S_WAIT;
            r_wait_cnt <= 8'd1;
          end
        end
        S_WAIT: begin
          if (!br_valid) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 8'd0;
          end else if (w_ops_ready || w_timeout) begin
            r_state    <= S_RES;
            r_wait_cnt <= 8'd0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        S_RES: begin
          r_state    <= S_IDLE;
          r_wait_cnt <= 8'd0;
          if (r_taken && !(&r_tcnt))
            r_tcnt <= r_tcnt + COUNT_W'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall     = w_stall;
  assign br_done   = (r_state == S_RES);
  assign br_taken  = r_taken;
  assign br_target = r_target;
  assign err       = r_err;
  assign taken_cnt = r_tcnt;
  assign stall_cnt = r_scnt;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: vector table, directed corner sequences
// and randomized branches against a transaction-level reference.
module tb_branch_resolve_ctrl;

  localparam int MW   = 15;
  localparam int CW   = 8;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          br_valid = 1'b0;
  logic [2:0]    br_op = 3'd0;
  logic          rs_ready = 1'b0;
  logic          rt_ready = 1'b0;
  logic          cmp_equal = 1'b0;
  logic          cmp_g_or_e = 1'b0;
  logic          cmp_greater = 1'b0;
  logic [31:0]   id_pc = 32'd0;
  logic [15:0]   imm16 = 16'd0;
  logic          stall;
  logic          br_done;
  logic          br_taken;
  logic [31:0]   br_target;
  logic          err;
  logic [CW-1:0] taken_cnt;
  logic [CW-1:0] stall_cnt;

  branch_resolve_ctrl #(.MAX_WAIT(MW), .COUNT_W(CW)) dut (
    .clk(clk), .reset(reset), .br_valid(br_valid), .br_op(br_op),
    .rs_ready(rs_ready), .rt_ready(rt_ready), .cmp_equal(cmp_equal),
    .cmp_g_or_e(cmp_g_or_e), .cmp_greater(cmp_greater),
    .id_pc(id_pc), .imm16(imm16), .stall(stall), .br_done(br_done),
    .br_taken(br_taken), .br_target(br_target), .err(err),
    .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference state: last decision, sticky error, counters
  logic        m_taken;
  logic [31:0] m_target;
  logic        m_err;
  int          m_tcnt;
  int          m_scnt;
  bit          g_rt_only = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic ref_taken(input logic [2:0] op,
      input logic eq, input logic ge, input logic gt);
    case (op)
      3'd0: return eq;
      3'd1: return !eq;
      3'd2: return ge;
      3'd3: return gt;
      3'd4: return !gt;
      3'd5: return !ge;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_target(input logic [31:0] pc,
      input logic [15:0] imm);
    int off;
    off = int'($signed(imm)) * 4;
    return pc + 32'd4 + 32'(off);
  endfunction

  task automatic model_reset();
    m_taken = 1'b0; m_target = 32'd0; m_err = 1'b0;
    m_tcnt = 0; m_scnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    br_valid = 1'($urandom_range(0, 1));
    @(negedge clk);
    reset = 1'b1;
    br_valid = 1'b0;
    #1;
    model_reset();
    chk("rst_done", 32'(br_done), 32'd0);
    chk("rst_taken", 32'(br_taken), 32'd0);
    chk("rst_target", br_target, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_tcnt", 32'(taken_cnt), 32'd0);
    chk("rst_scnt", 32'(stall_cnt), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
  endtask

  // k: not-ready cycles before operands arrive; fl>0: drop br_valid
  // after fl not-ready cycles (fl <= MW)
  task automatic do_branch(input logic [2:0] op, input logic eq,
      input logic ge, input logic gt, input logic [31:0] pc,
      input logic [15:0] imm, input int k, input int fl);
    int  n;
    bit  tmo;
    n   = (fl > 0) ? fl : ((k < MW) ? k : MW) + 1;
    tmo = (fl == 0) && (k > MW);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      br_valid = 1'b1; br_op = op; id_pc = pc; imm16 = imm;
      cmp_equal = eq; cmp_g_or_e = ge; cmp_greater = gt;
      if (c <= k || fl > 0) begin
        if (op < 3'd2 && (g_rt_only || $urandom_range(0, 1) == 1)) begin
          rs_ready = 1'b1; rt_ready = 1'b0;
        end else begin
          rs_ready = 1'b0; rt_ready = 1'($urandom_range(0, 1));
        end
      end else begin
        rs_ready = 1'b1;
        rt_ready = (op < 3'd2) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      #1;
      chk("stall_hi", 32'(stall), 32'd1);
      chk("done_lo", 32'(br_done), 32'd0);
      if (m_scnt != MAXC) m_scnt++;
    end
    if (fl > 0) begin
      @(negedge clk);
      br_valid = 1'b0;
      #1;
      chk("flush_stall", 32'(stall), 32'd0);
      chk("flush_done", 32'(br_done), 32'd0);
      @(negedge clk);
      #1;
      chk("flush_nodone", 32'(br_done), 32'd0);
      chk("flush_taken", 32'(br_taken), 32'(m_taken));
      chk("flush_target", br_target, m_target);
      chk("flush_scnt", 32'(stall_cnt), 32'(m_scnt));
      return;
    end
    m_taken  = tmo ? 1'b0 : ref_taken(op, eq, ge, gt);
    m_target = ref_target(pc, imm);
    m_err    = m_err | tmo | (op >= 3'd6);
    @(negedge clk);
    br_valid = 1'($urandom_range(0, 1));
    rs_ready = 1'($urandom_range(0, 1));
    #1;
    chk("res_stall", 32'(stall), 32'd0);
    chk("res_done", 32'(br_done), 32'd1);
    chk("res_taken", 32'(br_taken), 32'(m_taken));
    chk("res_target", br_target, m_target);
    chk("res_err", 32'(err), 32'(m_err));
    if (m_taken && m_tcnt != MAXC) m_tcnt++;
    @(negedge clk);
    br_valid = 1'b0;
    #1;
    chk("post_done", 32'(br_done), 32'd0);
    chk("post_stall", 32'(stall), 32'd0);
    chk("post_tcnt", 32'(taken_cnt), 32'(m_tcnt));
    chk("post_scnt", 32'(stall_cnt), 32'(m_scnt));
    chk("post_taken", 32'(br_taken), 32'(m_taken));
  endtask

  typedef struct {
    logic [2:0]  op;
    logic        eq, ge, gt;
    logic [31:0] pc;
    logic [15:0] imm;
    logic        tk;
    logic [31:0] tgt;
    logic        er;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int s0;
    tbl[0]  = '{3'd0, 1'b1, 1'b0, 1'b0, 32'h00003000, 16'h0004,
                1'b1, 32'h00003014, 1'b0};
    tbl[1]  = '{3'd5, 1'b0, 1'b0, 1'b0, 32'h00000000, 16'hFFFE,
                1'b1, 32'hFFFFFFFC, 1'b0};
    tbl[2]  = '{3'd1, 1'b1, 1'b0, 1'b0, 32'h00001000, 16'h0010,
                1'b0, 32'h00001044, 1'b0};
    tbl[3]  = '{3'd2, 1'b0, 1'b1, 1'b0, 32'h00002000, 16'h8000,
                1'b1, 32'hFFFE2004, 1'b0};
    tbl[4]  = '{3'd3, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFC, 16'h0000,
                1'b0, 32'h00000000, 1'b0};
    tbl[5]  = '{3'd4, 1'b0, 1'b0, 1'b0, 32'h00000100, 16'h7FFF,
                1'b1, 32'h00020100, 1'b0};
    tbl[6]  = '{3'd3, 1'b0, 1'b1, 1'b1, 32'h00000040, 16'h0001,
                1'b1, 32'h00000048, 1'b0};
    tbl[7]  = '{3'd4, 1'b0, 1'b1, 1'b1, 32'h00000040, 16'hFFFF,
                1'b0, 32'h00000040, 1'b0};
    tbl[8]  = '{3'd1, 1'b0, 1'b0, 1'b0, 32'h00000010, 16'h0002,
                1'b1, 32'h0000001C, 1'b0};
    tbl[9]  = '{3'd0, 1'b0, 1'b1, 1'b1, 32'h00000000, 16'h0000,
                1'b0, 32'h00000004, 1'b0};
    tbl[10] = '{3'd7, 1'b1, 1'b1, 1'b1, 32'h00000500, 16'h0001,
                1'b0, 32'h00000508, 1'b1};

    model_reset();
    do_reset();

    foreach (tbl[i]) begin
      do_branch(tbl[i].op, tbl[i].eq, tbl[i].ge, tbl[i].gt,
                tbl[i].pc, tbl[i].imm, 0, 0);
      chk($sformatf("tbl%0d_taken", i), 32'(br_taken), 32'(tbl[i].tk));
      chk($sformatf("tbl%0d_target", i), br_target, tbl[i].tgt);
      chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].er));
      if (i == 0) chk("tbl0_tcnt", 32'(taken_cnt), 32'd1);
    end

    // load-use: rt late by 3 cycles
    do_reset();
    g_rt_only = 1'b1;
    do_branch(3'd1, 1'b1, 1'b0, 1'b0, 32'h00004000, 16'h0008, 3, 0);
    g_rt_only = 1'b0;
    chk("lu_scnt", 32'(stall_cnt), 32'd4);
    chk("lu_taken", 32'(br_taken), 32'd0);
    chk("lu_err", 32'(err), 32'd0);

    // flush while waiting keeps the previous decision
    do_branch(3'd0, 1'b1, 1'b0, 1'b0, 32'h00000200, 16'h0003, 0, 0);
    do_branch(3'd1, 1'b1, 1'b0, 1'b0, 32'h00000900, 16'h0001, 0, 2);
    chk("fl_keep_taken", 32'(br_taken), 32'd1);
    chk("fl_keep_tgt", br_target, 32'h00000210);
    do_branch(3'd3, 1'b0, 1'b1, 1'b1, 32'h00000900, 16'h0001, 0, MW);

    // timeout, then error stays sticky through good branches
    s0 = m_scnt;
    do_branch(3'd2, 1'b0, 1'b1, 1'b1, 32'h00006000, 16'h0004, 40, 0);
    chk("tmo_scnt_delta", 32'(int'(stall_cnt) - s0), 32'd16);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_taken", 32'(br_taken), 32'd0);
    do_branch(3'd0, 1'b1, 1'b1, 1'b1, 32'h00006100, 16'h0004, 0, 0);
    chk("tmo_err_sticky", 32'(err), 32'd1);
    chk("tmo_next_taken", 32'(br_taken), 32'd1);

    // reset while waiting
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      br_valid = 1'b1; br_op = 3'd1; rs_ready = 1'b1; rt_ready = 1'b0;
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    chk("rw_done", 32'(br_done), 32'd0);
    chk("rw_taken", 32'(br_taken), 32'd0);
    chk("rw_target", br_target, 32'd0);
    chk("rw_err", 32'(err), 32'd0);
    chk("rw_tcnt", 32'(taken_cnt), 32'd0);
    chk("rw_scnt", 32'(stall_cnt), 32'd0);
    chk("rw_stall_v1", 32'(stall), 32'd1);
    br_valid = 1'b0;
    #1;
    chk("rw_stall_v0", 32'(stall), 32'd0);

    // randomized branches
    for (int t = 0; t < 300; t++) begin
      logic [2:0] op;
      int k, fl;
      op = ($urandom_range(0, 9) == 0) ? 3'(6 + $urandom_range(0, 1))
                                       : 3'($urandom_range(0, 5));
      k  = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 20)
                                       : $urandom_range(0, 3);
      fl = ($urandom_range(0, 7) == 0) ? $urandom_range(1, MW) : 0;
      do_branch(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom, 16'($urandom), k, fl);
    end

    // counter saturation
    do_reset();
    for (int t = 0; t < 20; t++)
      do_branch(3'd0, 1'b1, 1'b0, 1'b0, 32'h00000100, 16'h0001, 30, 0);
    chk("sat_scnt", 32'(stall_cnt), 32'(MAXC));
    for (int t = 0; t < 260; t++)
      do_branch(3'd0, 1'b1, 1'b0, 1'b0, 32'h00000100, 16'h0001, 0, 0);
    chk("sat_tcnt", 32'(taken_cnt), 32'(MAXC));
    chk("sat_scnt2", 32'(stall_cnt), 32'(MAXC));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
